pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. Combinationally generates the stall/bubble/set_cc controls consumed by the fetch, decode, execute, memory and write-back pipeline registers from load/use, `ret` and mispredicted-branch hazards. Sequentially tracks processor status through a RUN/DRAIN/HALTED state machine and maintains saturating performance counters. Sits beside the datapath; it owns no datapath registers.

## Interface
- `CNT_W`, default 32: width of each performance counter.
- `clk` in 1: pipeline clock, all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `D_icode` in 4: icode in D register.
- `d_srcA`, `d_srcB` in 4 each: decode-stage source register IDs (0xF = none).
- `E_icode` in 4, `E_dstM` in 4: E register icode and load destination.
- `e_cnd` in 1: execute-stage condition result.
- `M_icode` in 4: M register icode.
- `m_stat` in 2, `W_stat` in 2: memory-stage and W register status (0 AOK, 1 HLT, 2 ADR, 3 INS).
- `W_icode` in 4: W register icode.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`, `set_cc` out 1 each: pipeline controls.
- `halted` out 1: pipeline frozen.
- `cpu_stat` out 2: architectural status.
- `cyc_cnt`, `ret_cnt`, `lu_cnt`, `mp_cnt`, `rt_cnt` out `CNT_W` each: cycles, retired instructions, load/use stalls, mispredicts, `ret` stall cycles.

## Operation
- Icodes: HALT 0, NOP 1, CMOV 2, IRMOV 3, RMMOV 4, MRMOV 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSH A, POP B.
- Hazard terms:
  - `lu`: E_icode ∈ {MRMOV, POP} and E_dstM ≠ 0xF and E_dstM ∈ {d_srcA, d_srcB}.
  - `rt`: RET ∈ {D_icode, E_icode, M_icode}.
  - `mp`: E_icode = JXX and !e_cnd.
  - `exc_m`: m_stat ≠ AOK. `exc_w`: W_stat ≠ AOK.
- Controls in RUN/DRAIN:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (!lu & rt).
  - E_bubble = mp | lu.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
  - set_cc = (E_icode = OPQ) & !exc_m & !exc_w.
- State machine, states RUN, DRAIN, HALTED:
  - RUN→HALTED if exc_w; else RUN→DRAIN if exc_m.
  - DRAIN→HALTED when exc_w. DRAIN never returns to RUN.
  - HALTED is absorbing until reset.
- In HALTED: F_stall = D_stall = W_stall = 1, E_bubble = M_bubble = 1, D_bubble = set_cc = 0. Hazard terms are ignored.
- Status outputs:
  - `cpu_stat` = AOK in RUN/DRAIN. On entry to HALTED it latches W_stat and holds it.
  - `halted` = 1 only in HALTED.
- Counters, all saturating at all-ones, counting only outside HALTED:
  - `cyc_cnt`: +1 per cycle.
  - `ret_cnt`: +1 when W_stat = AOK and W_icode ∉ {NOP}. A HALT reaching W with AOK is not possible, since HLT status accompanies it.
  - `lu_cnt`: +1 per cycle with lu.
  - `mp_cnt`: +1 per cycle with mp.
  - `rt_cnt`: +1 per cycle with rt & !lu.

## Timing
- Control outputs are combinational from current inputs and current state, with zero-cycle latency. There is no combinational path from outputs back to inputs.
- FSM, `cpu_stat`, `halted` and counters update on the rising clk edge after the triggering condition. `halted` rises one cycle after exc_w is first seen.
- Reset values: state RUN, `cpu_stat` AOK, `halted` 0, all counters 0. Control outputs then follow the equations above.
- Reset asserted mid-operation (including HALTED) returns immediately to RUN with counters cleared.
- Simultaneous lu & rt: D stalls, no D bubble, rt_cnt not incremented.
- Simultaneous mp & rt: F_stall = D_bubble = E_bubble = 1.
- Simultaneous exc_m & exc_w: go directly to HALTED.
- exc_m gates set_cc in the same cycle.

## Structure
- Shared package `y86_pkg`: icode constants, stat encodings, register ID RNONE = 0xF. The existing fetch/decode/execute stages reuse it.
- One sub-module, `sat_counter` (parameter width, inputs inc/clr, saturating). It is instantiated five times. Hazard logic and FSM stay inline.

## Test plan
- Load/use: E_icode = 5, E_dstM = 3, d_srcA = 3 → F_stall = D_stall = E_bubble = 1, D_bubble = 0; lu_cnt increments by 1 next edge.
- Mispredict: E_icode = 7, e_cnd = 0 → D_bubble = E_bubble = 1, F_stall = 0; mp_cnt = 1.
- Ret: D_icode = 9 held 3 cycles (D, then E, then M) → F_stall = D_bubble = 1 each cycle; rt_cnt = 3.
- Exception drain: m_stat = ADR with W_stat = AOK, then W_stat = ADR next cycle → M_bubble = 1, set_cc = 0 with E_icode = 6. State goes DRAIN then HALTED, `halted` = 1, `cpu_stat` = 2, and counters freeze.
- Combined: lu & rt (E_icode = B matching d_srcB, M_icode = 9) → D_stall = 1, D_bubble = 0. mp & D_icode = 9 → F_stall = D_bubble = E_bubble = 1.
- Reset/saturation: with CNT_W = 4, run 20 cycles → cyc_cnt = 15. Assert rst_n low asynchronously while HALTED → immediately all counters 0, `halted` = 0, `cpu_stat` = 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status encodings, register IDs and
// the pipeline-control FSM state type.
package y86_pkg;

  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } ctrl_state_t;

  // True for instructions that write a register from memory.
  function automatic logic isLoad(input logic [3:0] icode);
    return (icode == I_MRMOV) || (icode == I_POP);
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, holding once all-ones is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard-driven stall/bubble generation, processor
// status FSM (RUN/DRAIN/HALTED) and saturating performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] rt_cnt
);

  ctrl_state_t state, stateNext;
  logic [1:0]  statReg;

  logic lu, rt, mp, excM, excW;
  logic active;

  // Hazard terms from the current pipeline-register contents.
  always_comb begin
    lu   = isLoad(E_icode) && (E_dstM != RNONE) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp   = (E_icode == I_JXX) && !e_cnd;
    excM = (m_stat != STAT_AOK);
    excW = (W_stat != STAT_AOK);
  end

  // Status FSM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and pipeline controls; HALTED freezes everything.
  always_comb begin
    stateNext = state;
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    set_cc    = 1'b0;
    unique case (state)
      S_HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: begin
        if (excW) begin
          stateNext = S_HALTED;
        end else if (excM) begin
          stateNext = S_DRAIN;
        end
        F_stall  = lu | rt;
        D_stall  = lu;
        D_bubble = mp | (!lu & rt);
        E_bubble = mp | lu;
        M_bubble = excM | excW;
        W_stall  = excW;
        set_cc   = (E_icode == I_OPQ) & !excM & !excW;
      end
    endcase
  end

  // Architectural status: latched from W on entry to HALTED, held after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statReg <= STAT_AOK;
    end else if ((state != S_HALTED) && excW) begin
      statReg <= W_stat;
    end
  end

  assign cpu_stat = statReg;
  assign halted   = (state == S_HALTED);
  assign active   = (state != S_HALTED);

  sat_counter #(.WIDTH(CNT_W)) uCyc (
    .clk(clk), .rst_n(rst_n), .inc(active), .clr(1'b0), .count(cyc_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) uRet (
    .clk(clk), .rst_n(rst_n),
    .inc(active && !excW && (W_icode != I_NOP)),
    .clr(1'b0), .count(ret_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) uLu (
    .clk(clk), .rst_n(rst_n), .inc(active && lu), .clr(1'b0), .count(lu_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) uMp (
    .clk(clk), .rst_n(rst_n), .inc(active && mp), .clr(1'b0), .count(mp_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) uRt (
    .clk(clk), .rst_n(rst_n), .inc(active && rt && !lu), .clr(1'b0),
    .count(rt_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: a 32-bit instance and a 4-bit
// instance share all stimulus; the narrow one exercises saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic       e_cnd;
  logic [1:0] m_stat, W_stat;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic        halted;
  logic [1:0]  cpu_stat;
  logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rt_cnt;

  logic        sF_stall, sD_stall, sD_bubble, sE_bubble, sM_bubble, sW_stall;
  logic        sSet_cc, sHalted;
  logic [1:0]  sCpu_stat;
  logic [3:0]  sCyc, sRet, sLu, sMp, sRt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .set_cc(set_cc), .halted(halted), .cpu_stat(cpu_stat),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt),
    .rt_cnt(rt_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dutS (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
    .F_stall(sF_stall), .D_stall(sD_stall), .D_bubble(sD_bubble),
    .E_bubble(sE_bubble), .M_bubble(sM_bubble), .W_stall(sW_stall),
    .set_cc(sSet_cc), .halted(sHalted), .cpu_stat(sCpu_stat),
    .cyc_cnt(sCyc), .ret_cnt(sRet), .lu_cnt(sLu), .mp_cnt(sMp), .rt_cnt(sRt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setIdle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b0;
    M_icode = 4'h1; m_stat = 2'd0; W_stat = 2'd0; W_icode = 4'h1;
  endtask

  task automatic doReset();
    setIdle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    setIdle();
    #2;
    check("rst_halted", halted, 0);
    check("rst_cpu_stat", cpu_stat, 0);
    check("rst_cyc", cyc_cnt, 0);
    check("rst_ctrls", {F_stall, D_stall, D_bubble, E_bubble, M_bubble,
                        W_stall, set_cc}, 0);
    tick();
    check("rst_hold_cyc", cyc_cnt, 0);
    rst_n = 1'b1;

    // Idle run: wide counts 20, narrow saturates at 15; NOPs in W don't retire.
    repeat (20) tick();
    check("idle_cyc32", cyc_cnt, 20);
    check("sat_cyc4", sCyc, 15);
    check("idle_ret", ret_cnt, 0);
    E_icode = 4'h6;
    #1;
    check("opq_set_cc", set_cc, 1);

    // Load/use on srcA.
    doReset();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    check("lu_ctrls", {F_stall, D_stall, E_bubble, D_bubble}, 4'b1110);
    tick();
    check("lu_cnt", lu_cnt, 1);
    check("lu_cyc", cyc_cnt, 1);
    setIdle();
    #1;
    check("lu_gone_dstall", D_stall, 0);
    tick();
    check("lu_cnt_hold", lu_cnt, 1);

    // Load into RNONE is not a hazard even if the source matches.
    E_icode = 4'hB; E_dstM = 4'hF; d_srcB = 4'hF;
    #1;
    check("lu_rnone", {D_stall, E_bubble}, 2'b00);
    setIdle();

    // Mispredict, then a taken branch.
    doReset();
    E_icode = 4'h7; e_cnd = 1'b0;
    #1;
    check("mp_ctrls", {D_bubble, E_bubble, F_stall, D_stall}, 4'b1100);
    tick();
    check("mp_cnt", mp_cnt, 1);
    e_cnd = 1'b1;
    #1;
    check("jxx_taken", {D_bubble, E_bubble}, 2'b00);
    tick();
    check("mp_cnt_hold", mp_cnt, 1);

    // ret walking through D, E, M.
    doReset();
    D_icode = 4'h9;
    #1;
    check("rt_D", {F_stall, D_bubble, D_stall}, 3'b110);
    tick();
    D_icode = 4'h1; E_icode = 4'h9;
    #1;
    check("rt_E", {F_stall, D_bubble}, 2'b11);
    tick();
    E_icode = 4'h1; M_icode = 4'h9;
    #1;
    check("rt_M", {F_stall, D_bubble}, 2'b11);
    tick();
    check("rt_cnt", rt_cnt, 3);
    setIdle();

    // Retirement counting.
    W_icode = 4'h6;
    tick();
    tick();
    W_icode = 4'h1;
    tick();
    check("ret_cnt", ret_cnt, 2);

    // lu & rt together.
    doReset();
    E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; M_icode = 4'h9;
    #1;
    check("lurt_ctrls", {D_stall, D_bubble, F_stall, E_bubble}, 4'b1011);
    tick();
    check("lurt_lu", lu_cnt, 1);
    check("lurt_rt", rt_cnt, 0);

    // mp & ret in D together.
    setIdle();
    E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9;
    #1;
    check("mprt_ctrls", {F_stall, D_bubble, E_bubble, D_stall}, 4'b1110);
    tick();
    check("mprt_mp", mp_cnt, 2'd1);
    check("mprt_rt", rt_cnt, 1);

    // Exception drain: ADR in M, then in W.
    doReset();
    E_icode = 4'h6; m_stat = 2'd2;
    #1;
    check("exm_ctrls", {M_bubble, set_cc, W_stall}, 3'b100);
    tick();
    check("drain_halted", halted, 0);
    check("drain_stat", cpu_stat, 0);
    W_stat = 2'd2; W_icode = 4'h6;
    #1;
    check("exw_ctrls", {W_stall, M_bubble, set_cc}, 3'b110);
    tick();
    check("halt_halted", halted, 1);
    check("halt_stat", cpu_stat, 2);
    check("halt_cyc", cyc_cnt, 2);
    check("halt_ctrls", {F_stall, D_stall, D_bubble, E_bubble, M_bubble,
                         W_stall, set_cc}, 7'b1101110);
    setIdle();
    E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; W_icode = 4'h6;
    repeat (3) tick();
    check("frozen_cyc", cyc_cnt, 2);
    check("frozen_lu", lu_cnt, 0);
    check("frozen_ret", ret_cnt, 0);
    check("held_stat", cpu_stat, 2);
    check("held_halted", halted, 1);

    // Asynchronous reset while HALTED, mid-cycle.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cyc", cyc_cnt, 0);
    check("arst_halted", halted, 0);
    check("arst_stat", cpu_stat, 0);
    check("arst_small", {sHalted, sCyc}, 0);
    rst_n = 1'b1;
    setIdle();

    // exc_m and exc_w together go straight to HALTED.
    tick();
    m_stat = 2'd1; W_stat = 2'd3;
    tick();
    check("dual_halted", halted, 1);
    check("dual_stat", cpu_stat, 3);
    doReset();
    check("final_rst_halted", halted, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
